// File: rtl/pattern_detector_pkg.sv
// ---------------------------------------------------------------------------
// pattern_detector_pkg
// Shared types and constants for the programmable serial pattern detector.
//   state_t      : search progress (S_IDLE / S_FILL / S_ARMED)
//   PAT_LEN_MAX  : largest supported pattern length
//   MODE_NOVL    : match mode, non-overlapping (window restarts after a hit)
//   MODE_OVL     : match mode, overlapping (window keeps sliding after a hit)
// ---------------------------------------------------------------------------
package pattern_detector_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // no bits held
        S_FILL  = 2'd1,   // 1..PAT_LEN-1 bits held
        S_ARMED = 2'd2    // full window held, every valid bit is compared
    } state_t;

    localparam int   PAT_LEN_MAX = 32;

    localparam logic MODE_NOVL = 1'b0;
    localparam logic MODE_OVL  = 1'b1;

endpackage : pattern_detector_pkg

// File: rtl/pd_sat_counter.sv
// ---------------------------------------------------------------------------
// pd_sat_counter
// Generic up-counter that stops at MAX_VAL, with a synchronous clear that
// takes priority over the increment.
// Ports:
//   clk_i  in  1  clock, rising edge
//   rst_i  in  1  asynchronous active-high reset, counter -> 0
//   clr_i  in  1  synchronous clear
//   inc_i  in  1  increment request (ignored once MAX_VAL is reached)
//   cnt_o  out W  current count
// ---------------------------------------------------------------------------
module pd_sat_counter #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   MAX_VAL = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != MAX_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule : pd_sat_counter

// File: rtl/pattern_detector_param.sv
// ---------------------------------------------------------------------------
// pattern_detector_param
// Serial bit-stream detector for a runtime-programmable PAT_LEN-bit pattern.
// The first received bit of the pattern is pat bit PAT_LEN-1. A registered
// one-cycle pulse is produced on the edge that samples the completing bit.
// In non-overlapping mode the search restarts from scratch after a hit; in
// overlapping mode the window keeps sliding so back-to-back hits are possible.
//
// Optional feature macro: PATTERN_DETECTOR_MATCH_COUNT_EN
//   When defined, match_cnt_o counts hits (saturating, cleared by reset and
//   by pat_load_i). When undefined, the port and its counter do not exist.
//
// Ports:
//   clk_i               in   1        clock, rising edge
//   rst_i               in   1        asynchronous active-high reset
//   d_i                 in   1        serial data bit
//   valid_i             in   1        d_i is sampled only when 1
//   pat_load_i          in   1        load pat_i/overlap_i and restart search
//   pat_i               in   PAT_LEN  new pattern
//   overlap_i           in   1        new match mode (1 = overlapping)
//   pattern_detected_o  out  1        one-cycle match pulse
//   match_cnt_o         out  CNT_W    hits since reset/load (macro only)
// ---------------------------------------------------------------------------
module pattern_detector_param
    import pattern_detector_pkg::*;
#(
    parameter int                 PAT_LEN   = 5,
    parameter logic [PAT_LEN-1:0] PAT_RESET = 5'b11011,
    parameter logic               OVL_RESET = 1'b0,
    parameter int                 CNT_W     = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               d_i,
    input  logic               valid_i,
    input  logic               pat_load_i,
    input  logic [PAT_LEN-1:0] pat_i,
    input  logic               overlap_i,
    output logic               pattern_detected_o
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt_o
`endif
);

    localparam int   FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic PARAMS_OK = (PAT_LEN >= 2) && (PAT_LEN <= PAT_LEN_MAX) && (CNT_W >= 1);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("pattern_detector_param: PAT_LEN must be 2..32 and CNT_W >= 1");
        end
    endgenerate

    logic [PAT_LEN-1:0] r_pat;
    logic               r_ovl;
    logic [PAT_LEN-1:0] r_hist;
    logic               r_detected;
    state_t             r_state;
    state_t             w_state_next;

    logic [FILL_W-1:0]  w_fill;
    logic [PAT_LEN-1:0] w_nxt;
    logic               w_accept;
    logic               w_window_full;
    logic               w_match;
    logic               w_restart;

    // A load owns the cycle: the data bit offered alongside it is dropped.
    assign w_accept      = valid_i && !pat_load_i;
    assign w_nxt         = {r_hist[PAT_LEN-2:0], d_i};
    // With PAT_LEN-1 bits already held, the incoming bit completes a window.
    assign w_window_full = (w_fill >= FILL_W'(PAT_LEN - 1));
    assign w_match       = w_accept && w_window_full && (w_nxt == r_pat);
    // Non-overlapping hits consume the whole window.
    assign w_restart     = w_match && (r_ovl == MODE_NOVL);

    // Bit-fill counter: saturates once a full window is held so the compare
    // keeps firing on every later valid bit.
    pd_sat_counter #(
        .W       (FILL_W),
        .MAX_VAL (FILL_W'(PAT_LEN))
    ) u_fill_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (pat_load_i || w_restart),
        .inc_i (valid_i),
        .cnt_o (w_fill)
    );

`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
    pd_sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (pat_load_i),
        .inc_i (w_match),
        .cnt_o (match_cnt_o)
    );
`endif

    // Pattern, mode, history and the registered pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pat      <= PAT_RESET;
            r_ovl      <= OVL_RESET;
            r_hist     <= '0;
            r_detected <= 1'b0;
        end else begin
            r_detected <= w_match;
            if (pat_load_i) begin
                r_pat  <= pat_i;
                r_ovl  <= overlap_i;
                r_hist <= '0;
            end else if (valid_i) begin
                r_hist <= w_restart ? '0 : w_nxt;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: tracks how much of the window is populated.
    always_comb begin
        w_state_next = r_state;
        if (pat_load_i) begin
            w_state_next = S_IDLE;
        end else if (valid_i) begin
            if (w_restart) begin
                w_state_next = S_IDLE;
            end else if (w_window_full) begin
                w_state_next = S_ARMED;
            end else begin
                w_state_next = S_FILL;
            end
        end
    end

    assign pattern_detected_o = r_detected;

endmodule : pattern_detector_param

// File: tb/tb_pattern_detector_param.sv
module tb_pattern_detector_param;

    localparam int PL = 5;

    logic          clk        = 1'b0;
    logic          rst_i      = 1'b0;
    logic          d_i        = 1'b0;
    logic          valid_i    = 1'b0;
    logic          pat_load_i = 1'b0;
    logic [PL-1:0] pat_i      = '0;
    logic          overlap_i  = 1'b0;
    logic          pd;
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
    logic [7:0]    cnt;
    logic          pd2;
    logic [1:0]    cnt2;
`endif

    always #5 clk = ~clk;

    pattern_detector_param dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .d_i                (d_i),
        .valid_i            (valid_i),
        .pat_load_i         (pat_load_i),
        .pat_i              (pat_i),
        .overlap_i          (overlap_i),
        .pattern_detected_o (pd)
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
        ,
        .match_cnt_o        (cnt)
`endif
    );

`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
    pattern_detector_param #(.CNT_W(2)) dut2 (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .d_i                (d_i),
        .valid_i            (valid_i),
        .pat_load_i         (pat_load_i),
        .pat_i              (pat_i),
        .overlap_i          (overlap_i),
        .pattern_detected_o (pd2),
        .match_cnt_o        (cnt2)
    );
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the bits received since the search last restarted,
    // the programmed pattern/mode, and the saturating hit counts.
    bit            m_bits[$];
    logic [PL-1:0] m_pat;
    bit            m_ovl;
    int            m_cnt;
    int            m_cnt2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat  = 5'b11011;
        m_ovl  = 1'b0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    function automatic bit window_match();
        int n;
        n = m_bits.size();
        if (n < PL) return 1'b0;
        for (int i = 0; i < PL; i++) begin
            if (m_bits[n-PL+i] != m_pat[PL-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_all(input string tag, input bit exp_pulse);
        check(tag, {31'd0, pd}, {31'd0, exp_pulse});
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
        check({tag, "_cnt"},  {24'd0, cnt},  m_cnt);
        check({tag, "_p2"},   {31'd0, pd2},  {31'd0, exp_pulse});
        check({tag, "_cnt2"}, {30'd0, cnt2}, m_cnt2);
`endif
    endtask

    // One clock cycle: apply inputs, predict, then sample 1 time unit after the edge.
    task automatic drive(input string tag, input bit v, input bit d,
                         input bit ld = 1'b0, input logic [PL-1:0] p = '0, input bit o = 1'b0);
        bit exp_pulse;
        exp_pulse  = 1'b0;
        valid_i    = v;
        d_i        = d;
        pat_load_i = ld;
        if (ld) begin
            pat_i     = p;
            overlap_i = o;
            m_bits.delete();
            m_pat  = p;
            m_ovl  = o;
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            // Pattern/mode inputs wander freely; without a load they must not matter.
            pat_i     = PL'($urandom);
            overlap_i = 1'($urandom);
            if (v) begin
                m_bits.push_back(d);
                if (m_bits.size() > PL) void'(m_bits.pop_front());
                if (window_match()) begin
                    exp_pulse = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                    if (!m_ovl) m_bits.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        $display("%0t %s v=%0b d=%0b ld=%0b pulse=%0b exp=%0b", $time, tag, v, d, ld, pd, exp_pulse);
        check_all(tag, exp_pulse);
    endtask

    task automatic stream(input string name, input logic [15:0] bits, input int n);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) begin
            drive($sformatf("%s_b%0d", name, n - i), 1'b1, b[i]);
        end
    endtask

    initial begin
        logic [PL-1:0] pats [5];
        pats[0] = 5'b11011; pats[1] = 5'b10101; pats[2] = 5'b11111;
        pats[3] = 5'b00000; pats[4] = 5'b01110;

        // Asynchronous reset, checked before any clock edge.
        #2 rst_i = 1'b1;
        model_reset();
        #1 check_all("reset_state", 1'b0);
        @(posedge clk);
        #2 rst_i = 1'b0;

        // Default pattern 11011.
        stream("dflt", 16'b11011, 5);

        // Non-overlapping: a single hit in 11011011.
        drive("load_novl", 1'b1, 1'b1, 1'b1, 5'b11011, 1'b0);
        stream("novl", 16'b11011011, 8);

        // Overlapping: hits after bits 5 and 8.
        drive("load_ovl", 1'b1, 1'b1, 1'b1, 5'b11011, 1'b1);
        stream("ovl", 16'b11011011, 8);

        // Gaps of three invalid cycles between each bit.
        drive("load_gap", 1'b0, 1'b0, 1'b1, 5'b11011, 1'b0);
        for (int i = 0; i < 5; i++) begin
            logic [4:0] g;
            g = 5'b11011;
            drive($sformatf("gap_v%0d", i), 1'b1, g[4-i]);
            for (int k = 0; k < 3; k++) drive($sformatf("gap_i%0d_%0d", i, k), 1'b0, 1'($urandom));
        end

        // Load mid-stream (with a valid bit offered on the load cycle).
        stream("pre_load", 16'b110, 3);
        drive("load_00111", 1'b1, 1'b1, 1'b1, 5'b00111, 1'b0);
        stream("p00111", 16'b00111, 5);

        // Reset asserted between edges while the pulse is high.
        stream("p00111b", 16'b00111, 5);
        #1 rst_i = 1'b1;
        model_reset();
        #1 check_all("rst_immediate", 1'b0);
        #3 rst_i = 1'b0;
        stream("pre_rst", 16'b1101, 4);
        #1 rst_i = 1'b1;
        #1 rst_i = 1'b0;
        model_reset();
        stream("post_rst", 16'b11011, 5);

        // All-ones overlapping pattern: continuous hits, narrow counter saturates.
        drive("load_ones", 1'b1, 1'b0, 1'b1, 5'b11111, 1'b1);
        stream("ones", 16'h01FF, 9);

        // Randomised traffic with occasional reprogramming.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                drive($sformatf("rnd%0d_load", i), 1'($urandom), 1'($urandom), 1'b1,
                      pats[$urandom_range(0, 4)], 1'($urandom));
            end else begin
                drive($sformatf("rnd%0d", i), ($urandom_range(0, 99) < 75), 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pattern_detector_param
